// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU,
// beq, jal). A registered main FSM walks the shared datapath through
// fetch/decode/execute/memory/writeback. All outputs and the next state are
// combinational from the current state and the decode inputs. The memory
// states (FETCH, MEMREAD, MEMWRITE) wait on MemReady.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, funct3,       instruction fields from IR
//   funct7b5
//   Zero              ALU zero flag, used only in BEQ
//   MemReady          memory finishes the current access this cycle
//   PCWrite, IRWrite  PC / IR+OldPC load enables
//   AdrSrc            memory address select (0 PC, 1 Result)
//   MemWrite          store request
//   ResultSrc         00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA           00 PC, 01 OldPC, 10 A
//   ALUSrcB           00 WriteData, 01 ImmExt, 10 constant 4
//   ALUControl        000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc            00 I, 01 S, 10 B, 11 J
//   RegWrite          write rd
//   IllegalOp         one-cycle pulse when an unsupported opcode is decoded
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalOp
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Internal ALU operation class handed to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    IllegalOp  = 1'b0;
    aluop      = ALUOP_ADD;

    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Speculatively form OldPC + imm so BEQ/JAL find the target in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            // PC was already advanced in FETCH, so the bad word is skipped.
            IllegalOp  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // Store request stays up for every wait cycle.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_next = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        aluop      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        aluop      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        aluop      = ALUOP_SUB;
        PCWrite    = Zero;
        state_next = FETCH;
      end
      JAL: begin
        // ALUResult = OldPC + 4 is kept in ALUOut for the ALUWB write to rd,
        // while PC loads the target computed in DECODE.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // While reset is held the outputs look like FETCH but nothing is written,
    // whatever state the aborted instruction had reached.
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      aluop     = ALUOP_ADD;
    end
  end

  always_comb begin
    case (aluop)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      default: begin
        case (funct3)
          // op[5] separates R-type sub from I-type addi, which has no subi.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Each instruction is expanded into the
// list of cycles it should take (including memory wait cycles) with the
// expected control outputs per cycle, then replayed against the DUT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
  );

  typedef struct packed {
    logic       pcw, irw, mw, rw, ill, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       mr;
    out_t       o;
  } cyc_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  cyc_t q[$];

  function automatic logic [6:0] op_of(int k);
    case (k)
      K_LW:  return 7'b0000011;
      K_SW:  return 7'b0100011;
      K_R:   return 7'b0110011;
      K_I:   return 7'b0010011;
      K_BEQ: return 7'b1100011;
      K_JAL: return 7'b1101111;
      default: return 7'b1110011;
    endcase
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] v;
    do v = 7'($urandom);
    while (v == 7'b0000011 || v == 7'b0100011 || v == 7'b0110011 ||
           v == 7'b0010011 || v == 7'b1100011 || v == 7'b1101111);
    return v;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Everything zero (add) except the state-independent ImmSrc.
  function automatic out_t blank(logic [6:0] o);
    out_t r = '0;
    r.imm = imm_of(o);
    return r;
  endfunction

  function automatic out_t fetch_look(logic [6:0] o);
    out_t r = blank(o);
    r.rs = 2'b10;
    r.sb = 2'b10;
    return r;
  endfunction

  task automatic push(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input logic mr, input out_t e);
    cyc_t c;
    c.rst = rst; c.op = o; c.f3 = f3; c.f7 = f7; c.z = z; c.mr = mr; c.o = e;
    q.push_back(c);
  endtask

  // Expected cycle list for one instruction: sf wait cycles in FETCH, sm wait
  // cycles in the data-memory phase, z is the Zero value seen in BEQ.
  task automatic add_instr(input int k, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int sf, input int sm);
    out_t e;
    for (int i = 0; i < sf; i++) push(0, o, f3, f7, 1'($urandom), 0, fetch_look(o));
    e = fetch_look(o); e.pcw = 1; e.irw = 1;
    push(0, o, f3, f7, 1'($urandom), 1, e);
    e = blank(o); e.sa = 2'b01; e.sb = 2'b01; e.ill = (k == K_ILL);
    push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
    case (k)
      K_LW, K_SW: begin
        e = blank(o); e.sa = 2'b10; e.sb = 2'b01;
        push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
        e = blank(o); e.adr = 1; e.mw = (k == K_SW);
        for (int i = 0; i < sm; i++) push(0, o, f3, f7, 1'($urandom), 0, e);
        push(0, o, f3, f7, 1'($urandom), 1, e);
        if (k == K_LW) begin
          e = blank(o); e.rs = 2'b01; e.rw = 1;
          push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
        end
      end
      K_R, K_I: begin
        e = blank(o); e.sa = 2'b10; e.sb = (k == K_I) ? 2'b01 : 2'b00;
        e.alu = alu_of(o, f3, f7);
        push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
        e = blank(o); e.rw = 1;
        push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
      end
      K_BEQ: begin
        e = blank(o); e.sa = 2'b10; e.alu = 3'b001; e.pcw = z;
        push(0, o, f3, f7, z, 1'($urandom), e);
      end
      K_JAL: begin
        e = blank(o); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1;
        push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
        e = blank(o); e.rw = 1;
        push(0, o, f3, f7, 1'($urandom), 1'($urandom), e);
      end
      default: ;
    endcase
  endtask

  task automatic step(input cyc_t c, output out_t a);
    @(negedge clk);
    reset = c.rst; op = c.op; funct3 = c.f3; funct7b5 = c.f7;
    Zero = c.z; MemReady = c.mr;
    #1;
    a = {PCWrite, IRWrite, MemWrite, RegWrite, IllegalOp, AdrSrc, ResultSrc,
         ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
  endtask

  task automatic test_reset();
    cyc_t c; out_t a; logic [6:0] o;
    int n = 0;
    // Power-up reset from an unknown state.
    for (int i = 0; i < 2; i++) push(1, 7'b0110011, 3'd0, 0, 0, 1, fetch_look(7'b0110011));
    // Start a stalled sw, abort it in MEMWRITE with 3 reset cycles.
    o = op_of(K_SW);
    add_instr(K_SW, o, 3'd0, 0, 0, 0, 6);
    while (q.size() > 6) begin
      c = q.pop_front(); step(c, a); total++;
      if (a !== c.o) begin bad++; $display("FAIL reset_pre cyc %0d: got %h want %h", n, a, c.o); end
      n++;
    end
    q.delete();
    for (int i = 0; i < 3; i++) push(1, o, 3'd0, 0, 1'($urandom), 1'($urandom), fetch_look(o));
    add_instr(K_R, op_of(K_R), 3'b111, 0, 0, 0, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c, a); total++;
      if (a !== c.o) begin bad++; $display("FAIL reset cyc %0d: got %h want %h", n, a, c.o); end
      n++;
    end
  endtask

  task automatic test_directed();
    cyc_t c; out_t a;
    int n = 0;
    add_instr(K_LW, op_of(K_LW), 3'b010, 0, 0, 0, 0);
    add_instr(K_SW, op_of(K_SW), 3'b010, 0, 0, 0, 2);
    add_instr(K_R, op_of(K_R), 3'b000, 1, 0, 0, 0);
    add_instr(K_I, op_of(K_I), 3'b000, 1, 0, 0, 0);
    add_instr(K_R, op_of(K_R), 3'b010, 0, 0, 0, 0);
    add_instr(K_I, op_of(K_I), 3'b110, 0, 0, 0, 0);
    add_instr(K_R, op_of(K_R), 3'b001, 1, 0, 0, 0);
    add_instr(K_BEQ, op_of(K_BEQ), 3'b000, 0, 1, 0, 0);
    add_instr(K_BEQ, op_of(K_BEQ), 3'b000, 0, 0, 0, 0);
    add_instr(K_ILL, 7'b1110011, 3'b000, 0, 0, 0, 0);
    add_instr(K_JAL, op_of(K_JAL), 3'b000, 0, 0, 0, 0);
    add_instr(K_LW, op_of(K_LW), 3'b010, 0, 0, 2, 3);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c, a); total++;
      if (a !== c.o) begin bad++; $display("FAIL directed cyc %0d: got %h want %h", n, a, c.o); end
      n++;
    end
  endtask

  task automatic test_random();
    cyc_t c; out_t a; int k; logic [6:0] o;
    int n = 0;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 6);
      o = (k == K_ILL) ? rand_illegal() : op_of(k);
      add_instr(k, o, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (q.size() > 0) begin
      c = q.pop_front(); step(c, a); total++;
      if (a !== c.o) begin bad++; $display("FAIL random cyc %0d: got %h want %h", n, a, c.o); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c; out_t a;
    int n = 0;
    for (int k = 0; k <= 6; k++) add_instr(k, op_of(k), 3'b111, 1, 1, 0, 0);
    add_instr(K_ILL, rand_illegal(), 3'b000, 0, 0, 0, 0);
    add_instr(K_ILL, rand_illegal(), 3'b000, 0, 0, 1, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); step(c, a); total++;
      if (a !== c.o) begin bad++; $display("FAIL b2b cyc %0d: got %h want %h", n, a, c.o); end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; MemReady = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
